// File: rtl/apb2wb_pkg.sv
// ============================================================================
//  Module      : apb2wb_pkg
//  Description : Shared types and constants for the APB4-to-Wishbone bridge.
//                Holds the bridge FSM state enum, the width of the optional
//                timeout counter and a small helper for the byte-select
//                policy (writes honour PSTRB, reads select all four lanes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb2wb_pkg;

    // Width of the response timeout counter (TIMEOUT parameter range 1..65535)
    localparam int TIMEOUT_W = 16;

    // Bridge sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for an APB access phase
        REQ  = 2'd1,   // strobe presented, waiting for the slave to accept it
        WAIT = 2'd2,   // request accepted, waiting for ack/err/rty
        DONE = 2'd3    // one-cycle PREADY pulse back to the APB master
    } state_t;

    // Byte lanes driven on the Wishbone side for a given APB access
    function automatic logic [3:0] wb_sel_for(input logic is_write,
                                              input logic [3:0] strb);
        return is_write ? strb : 4'hF;
    endfunction

endpackage : apb2wb_pkg

`default_nettype wire

// File: rtl/apb2wb_timer.sv
// ============================================================================
//  Module      : apb2wb_timer
//  Description : Response watchdog for the APB-to-Wishbone bridge. A
//                saturating counter is held at zero while i_clear is high
//                and advances once per cycle while i_enable is high.
//                o_expired is raised during the TIMEOUT-th enabled cycle so
//                the bridge can leave on the very edge that ends it; the
//                Wishbone cycle therefore lasts exactly TIMEOUT clocks.
//  Ports       : clk_i    - clock, rising edge
//                rst_n_i  - asynchronous active-low reset
//                i_clear  - hold the count at zero
//                i_enable - count this cycle
//                o_expired- TIMEOUT enabled cycles have elapsed (incl. this)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb2wb_timer
    import apb2wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Count value seen during the last permitted cycle
    localparam logic [TIMEOUT_W-1:0] c_LIMIT = TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            // Saturate at the limit so a late response cannot wrap it
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable & (r_count == c_LIMIT);

endmodule : apb2wb_timer

`default_nettype wire

// File: rtl/apb2wb_bridge.sv
// ============================================================================
//  Module      : apb2wb_bridge
//  Description : APB4 slave to pipelined Wishbone master bridge. One APB
//                access launches exactly one single-beat Wishbone cycle;
//                the response (ack / err / rty) is returned as a one-cycle
//                PREADY pulse with PRDATA/PSLVERR.
//                Minimum latency: PENABLE seen at edge N, STB at N+1, ACK at
//                N+2, PREADY at N+3 (N+2 when the slave acks in the same
//                cycle it accepts the strobe).
//  Options     : APB2WB_TIMEOUT_EN - when defined, a watchdog aborts a
//                Wishbone cycle that gets no response within TIMEOUT clocks
//                and reports PSLVERR=1, PRDATA=0. When undefined the bridge
//                waits indefinitely.
//  Ports       : clk_i, rst_n_i        - clock / async active-low reset
//                psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i
//                                      - APB4 request
//                prdata_o, pready_o, pslverr_o - APB4 completion
//                wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
//                                      - Wishbone master request
//                wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
//                                      - Wishbone slave response
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb2wb_bridge
    import apb2wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    // APB4 slave side
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic [3:0]            pstrb_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    // Wishbone pipelined master side
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-3:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_next;

    logic                  w_start;     // APB access phase in IDLE
    logic                  w_resp;      // any slave termination this cycle
    logic                  w_capture;   // termination accepted this cycle
    logic                  w_timeout;   // watchdog abort this cycle
    logic                  w_expired;   // watchdog limit reached
    logic                  w_busy;      // Wishbone cycle in progress

    logic                  r_we;
    logic [ADDR_WIDTH-3:0] r_adr;
    logic [3:0]            r_sel;
    logic [31:0]           r_dat;
    logic [31:0]           r_prdata;
    logic                  r_pslverr;

    // Byte offset bits never reach Wishbone (word-addressed bus)
    logic                  w_unused;
    assign w_unused = ^paddr_i[1:0];

    assign w_start = psel_i & penable_i;
    assign w_resp  = wb_ack_i | wb_err_i | wb_rty_i;
    assign w_busy  = (r_state == REQ) || (r_state == WAIT);

    // ------------------------------------------------------------------
    // Optional response watchdog
    // ------------------------------------------------------------------
`ifdef APB2WB_TIMEOUT_EN
    apb2wb_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_clear   (r_state == IDLE),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. A response seen while the strobe is still stalled
    // cannot belong to this request, so REQ only honours it together with
    // acceptance. A real response always wins over a simultaneous timeout.
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                if (!wb_stall_i && w_resp) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end else if (w_expired) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end else if (!wb_stall_i) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_resp) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end else if (w_expired) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch: captured once per transfer on the IDLE->REQ edge and
    // held stable for the whole Wishbone cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_we  <= 1'b0;
            r_adr <= '0;
            r_sel <= 4'h0;
            r_dat <= 32'h0;
        end else if ((r_state == IDLE) && w_start) begin
            r_we  <= pwrite_i;
            r_adr <= paddr_i[ADDR_WIDTH-1:2];
            r_sel <= wb_sel_for(pwrite_i, pstrb_i);
            r_dat <= pwdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Response capture. Data is only forwarded for an acked read; writes,
    // errors, retries and timeouts all return zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prdata  <= 32'h0;
            r_pslverr <= 1'b0;
        end else if (w_capture) begin
            r_prdata  <= (wb_ack_i && !r_we) ? wb_dat_i : 32'h0;
            r_pslverr <= wb_err_i | wb_rty_i;
        end else if (w_timeout) begin
            r_prdata  <= 32'h0;
            r_pslverr <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Bus controls decode straight from the state so that the
    // asynchronous reset drops CYC/STB without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign wb_cyc_o  = w_busy;
    assign wb_stb_o  = (r_state == REQ);
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_sel_o  = r_sel;
    assign wb_dat_o  = r_dat;

    assign pready_o  = (r_state == DONE);
    assign prdata_o  = r_prdata;
    assign pslverr_o = r_pslverr;

endmodule : apb2wb_bridge

`default_nettype wire

// File: tb/tb_apb2wb_bridge.sv
// ============================================================================
//  Module      : tb_apb2wb_bridge
//  Description : Self-checking bench for apb2wb_bridge. Each APB transfer is
//                described by its Wishbone slave behaviour (stall cycles S,
//                response delay D after acceptance, response kind); the
//                expected bus waveform follows from that description by
//                counting cycles after the PENABLE edge. Handles both
//                builds of the APB2WB_TIMEOUT_EN option.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb2wb_bridge;

    localparam int AW = 6;
    localparam int TO = 8;

    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_RTY  = 2;
    localparam int R_NONE = 3;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b1;
    logic          psel_i, penable_i, pwrite_i;
    logic [AW-1:0] paddr_i;
    logic [31:0]   pwdata_i;
    logic [3:0]    pstrb_i;
    logic [31:0]   prdata_o;
    logic          pready_o, pslverr_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-3:0] wb_adr_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;
    logic [31:0]   wb_dat_i;

    apb2wb_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwrite_i  (pwrite_i),
        .paddr_i   (paddr_i),
        .pwdata_i  (pwdata_i),
        .pstrb_i   (pstrb_i),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_rty_i  (wb_rty_i),
        .wb_stall_i(wb_stall_i),
        .wb_dat_i  (wb_dat_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Expected values driven by the transfer model
    logic          chk_en = 1'b0;
    logic          exp_cyc, exp_stb, exp_pready, exp_we, exp_err;
    logic [AW-3:0] exp_adr;
    logic [3:0]    exp_sel;
    logic [31:0]   exp_dat, exp_prdata;

    // Observations of the last transfer, pinned against literals
    int            obs_stb, obs_cyc, obs_rdy, obs_lat;
    logic [AW-3:0] obs_adr;
    logic [3:0]    obs_sel;
    logic          obs_we, obs_err;
    logic [31:0]   obs_prdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("cyc",    32'(wb_cyc_o), 32'(exp_cyc));
            chk("stb",    32'(wb_stb_o), 32'(exp_stb));
            chk("pready", 32'(pready_o), 32'(exp_pready));
            if (exp_cyc) begin
                chk("adr", 32'(wb_adr_o), 32'(exp_adr));
                chk("sel", 32'(wb_sel_o), 32'(exp_sel));
                chk("we",  32'(wb_we_o),  32'(exp_we));
                chk("dat", wb_dat_o, exp_dat);
            end
            if (exp_pready) begin
                chk("prdata",  prdata_o, exp_prdata);
                chk("pslverr", 32'(pslverr_o), 32'(exp_err));
            end
        end
    end

    task automatic exp_idle();
        exp_cyc = 1'b0; exp_stb = 1'b0; exp_pready = 1'b0;
    endtask

    // Slave noise while the bridge must ignore it
    task automatic wb_noise();
        wb_stall_i = 1'($urandom);
        wb_ack_i   = 1'($urandom);
        wb_err_i   = 1'($urandom);
        wb_rty_i   = 1'($urandom);
        wb_dat_i   = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            psel_i = 1'b0; penable_i = 1'b0;
            exp_idle();
            wb_noise();
        end
    endtask

    // One APB transfer. rst_at > 0 asserts reset during cycle rst_at.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [3:0] st,
                           input int s, input int d, input int resp,
                           input logic [31:0] rd, input int rst_at);
        int e;   // number of cycles CYC is high
`ifdef APB2WB_TIMEOUT_EN
        e = (resp == R_NONE) ? TO : s + 1 + d;
`else
        e = (resp == R_NONE) ? 1000000 : s + 1 + d;
`endif
        obs_stb = 0; obs_cyc = 0; obs_rdy = 0; obs_lat = 0;
        // setup phase
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
        paddr_i = addr; pwdata_i = wd; pstrb_i = st;
        exp_idle(); wb_noise();
        // access phase; the next edge is N
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        wb_noise();
        exp_adr    = addr[AW-1:2];
        exp_sel    = wr ? st : 4'hF;
        exp_we     = wr;
        exp_dat    = wd;
        exp_prdata = (resp == R_ACK && !wr) ? rd : 32'h0;
        exp_err    = (resp != R_ACK);
        for (int k = 1; k <= e + 1; k++) begin
            @(posedge clk_i); #1;
            exp_cyc    = (k <= e);
            exp_stb    = (k <= s + 1) && (k <= e);
            exp_pready = (k == e + 1);
            wb_stall_i = (k <= s);
            wb_ack_i   = (resp == R_ACK) && (k == s + 1 + d);
            wb_err_i   = (resp == R_ERR) && (k == s + 1 + d);
            wb_rty_i   = (resp == R_RTY) && (k == s + 1 + d);
            wb_dat_i   = (k == s + 1 + d) ? rd : $urandom;
            if (k == e + 1) wb_noise();
            if (wb_stb_o) obs_stb++;
            if (wb_cyc_o) obs_cyc++;
            if (k == 1) begin
                obs_adr = wb_adr_o; obs_sel = wb_sel_o; obs_we = wb_we_o;
            end
            if (pready_o) begin
                obs_rdy++; obs_lat = k; obs_prdata = prdata_o; obs_err = pslverr_o;
            end
            if (k == rst_at) begin
                chk("cyc_before_rst", 32'(wb_cyc_o), 32'd1);
                chk_en = 1'b0;
                #2 rst_n_i = 1'b0;
                #1;
                chk("rst_cyc",     32'(wb_cyc_o),  32'd0);
                chk("rst_stb",     32'(wb_stb_o),  32'd0);
                chk("rst_pready",  32'(pready_o),  32'd0);
                chk("rst_adr",     32'(wb_adr_o),  32'd0);
                chk("rst_sel",     32'(wb_sel_o),  32'd0);
                chk("rst_dat",     wb_dat_o,       32'd0);
                chk("rst_prdata",  prdata_o,       32'd0);
                chk("rst_pslverr", 32'(pslverr_o), 32'd0);
                psel_i = 1'b0; penable_i = 1'b0;
                exp_idle();
                @(posedge clk_i); #1;
                rst_n_i = 1'b1;
                chk_en  = 1'b1;
                break;
            end
        end
        if (rst_at == 0) begin
            @(posedge clk_i); #1;
            psel_i = 1'b0; penable_i = 1'b0;
            exp_idle(); wb_noise();
        end
    endtask

    initial begin
        psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = '0;
        pwdata_i = 0; pstrb_i = 0;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0; wb_dat_i = 0;
        exp_idle();
        exp_we = 0; exp_err = 0; exp_adr = '0; exp_sel = 0; exp_dat = 0; exp_prdata = 0;

        // Reset state
        #2 rst_n_i = 1'b0;
        #1;
        chk("reset_cyc",    32'(wb_cyc_o),  32'd0);
        chk("reset_pready", 32'(pready_o),  32'd0);
        chk("reset_sel",    32'(wb_sel_o),  32'd0);
        chk("reset_prdata", prdata_o,       32'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        chk_en  = 1'b1;
        idle_cycles(3);

        // Write 0x04 / DEADBEEF / strobes 0011, ack one cycle after stb
        run_txn(1'b1, 6'h04, 32'hDEADBEEF, 4'b0011, 0, 1, R_ACK, 32'h0, 0);
        chk("w_adr",   32'(obs_adr), 32'd1);
        chk("w_sel",   32'(obs_sel), 32'h3);
        chk("w_we",    32'(obs_we),  32'd1);
        chk("w_rdy",   32'(obs_rdy), 32'd1);
        chk("w_err",   32'(obs_err), 32'd0);
        chk("w_lat",   32'(obs_lat), 32'd3);
        idle_cycles(2);

        // Read 0x20 with two stall cycles
        run_txn(1'b0, 6'h20, 32'h0, 4'h0, 2, 1, R_ACK, 32'h12345678, 0);
        chk("r_stb_cycles", 32'(obs_stb), 32'd3);
        chk("r_prdata",     obs_prdata,   32'h12345678);
        chk("r_rdy",        32'(obs_rdy), 32'd1);
        chk("r_adr",        32'(obs_adr), 32'd8);
        chk("r_sel",        32'(obs_sel), 32'hF);

        // Read terminated by err
        run_txn(1'b0, 6'h10, 32'h0, 4'h0, 0, 2, R_ERR, 32'hCAFEF00D, 0);
        chk("err_pslverr", 32'(obs_err), 32'd1);
        chk("err_prdata",  obs_prdata,   32'd0);

        // Same-cycle accept and ack
        run_txn(1'b0, 6'h3C, 32'h0, 4'h0, 0, 0, R_ACK, 32'hA5A55A5A, 0);
        chk("fast_lat",    32'(obs_lat), 32'd2);
        chk("fast_prdata", obs_prdata,   32'hA5A55A5A);

        // Retry
        run_txn(1'b0, 6'h08, 32'h0, 4'h0, 1, 0, R_RTY, 32'h11112222, 0);
        chk("rty_pslverr", 32'(obs_err), 32'd1);

`ifdef APB2WB_TIMEOUT_EN
        // No response: watchdog ends the cycle
        run_txn(1'b0, 6'h14, 32'h0, 4'h0, 0, 0, R_NONE, 32'h0, 0);
        chk("to_cyc_cycles", 32'(obs_cyc), 32'd8);
        chk("to_pslverr",    32'(obs_err), 32'd1);
        chk("to_prdata",     obs_prdata,   32'd0);
`else
        // No response: cycle held until reset
        run_txn(1'b0, 6'h14, 32'h0, 4'h0, 0, 0, R_NONE, 32'h0, 1000);
        chk("hold_cyc_cycles", 32'(obs_cyc), 32'd1000);
        idle_cycles(2);
`endif

        // Reset while in WAIT, then a normal transfer
        run_txn(1'b0, 6'h18, 32'h0, 4'h0, 0, 5, R_ACK, 32'h99999999, 3);
        idle_cycles(4);
        run_txn(1'b1, 6'h2C, 32'h01020304, 4'b1100, 1, 1, R_ACK, 32'h0, 0);
        chk("post_rst_rdy", 32'(obs_rdy), 32'd1);
        chk("post_rst_err", 32'(obs_err), 32'd0);

        // Randomized transfers
        for (int t = 0; t < 60; t++) begin
            int r;
            int kind;
            r = $urandom_range(9, 0);
            kind = (r < 7) ? R_ACK : ((r == 7) ? R_ERR : R_RTY);
            run_txn(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                    $urandom_range(2, 0), $urandom_range(3, 0), kind, $urandom, 0);
            if (obs_rdy != 1) chk("rand_rdy_once", 32'(obs_rdy), 32'd1);
            idle_cycles($urandom_range(2, 0));
        end

        idle_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_apb2wb_bridge

`default_nettype wire

// File: doc/apb2wb_bridge.md
APB2WB_BRIDGE -- requirements
Module: apb2wb_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: byte-address width forwarded to Wishbone; word address is bits [ADDR_WIDTH-1:2].
REQ-002 Parameter TIMEOUT, default 255: Wishbone cycles waited for ack/err/rty before an abort; legal range 1..65535.
REQ-003 clk_i  in  1  single clock; all logic rising-edge.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 psel_i, penable_i, pwrite_i  in  1 each  APB4 control.
REQ-006 paddr_i  in  ADDR_WIDTH  APB byte address.
REQ-007 pwdata_i  in  32  write data; pstrb_i  in  4  byte strobes.
REQ-008 prdata_o  out  32  read data; pready_o  out  1  transfer done; pslverr_o  out  1  error.
REQ-009 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone pipelined master control.
REQ-010 wb_adr_o  out  ADDR_WIDTH-2  word address; wb_sel_o  out  4; wb_dat_o  out  32.
REQ-011 wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each; wb_dat_i  in  32.

Function
REQ-012 FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-013 IDLE -> REQ when psel_i & penable_i; on that edge latch paddr_i[ADDR_WIDTH-1:2], pwdata_i, pwrite_i, and wb_sel_o = pwrite_i ? pstrb_i : 4'hF.
REQ-014 REQ: wb_cyc_o=1, wb_stb_o=1; on !wb_stall_i go to WAIT, or straight to DONE if ack/err/rty is also sampled that cycle.
REQ-015 WAIT: wb_cyc_o=1, wb_stb_o=0; the first cycle with wb_ack_i|wb_err_i|wb_rty_i goes to DONE.
REQ-016 Response capture: prdata_o <= wb_dat_i on ack of a read, else 32'h0; pslverr_o <= wb_err_i|wb_rty_i.
REQ-017 DONE: pready_o=1 for exactly one cycle, wb_cyc_o=0; DONE -> IDLE unconditionally.
REQ-018 Minimum latency: penable_i high at edge N, stb at N+1, ack at N+2, pready_o at N+3.
REQ-019 pready_o=0 in every state except DONE; no second Wishbone cycle starts before DONE is left.
REQ-020 psel_i dropped while in REQ/WAIT (protocol violation): the Wishbone cycle completes, DONE still pulses, and the result is discarded by the master.
REQ-021 wb_ack_i/wb_err_i sampled in IDLE or DONE are ignored.

Reset
REQ-022 Asserting rst_n_i asynchronously forces IDLE and sets all outputs to 0 (prdata_o=0, pslverr_o=0, wb_cyc_o=0, wb_stb_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0).
REQ-023 Reset mid-transfer drops wb_cyc_o immediately; no pready_o pulse follows for the aborted transfer.

Configuration
REQ-024 Macro APB2WB_TIMEOUT_EN defined: a 16-bit counter clears on IDLE->REQ and increments in REQ/WAIT; reaching TIMEOUT forces DONE with pslverr_o=1 and prdata_o=0, dropping cyc/stb.
REQ-025 Macro APB2WB_TIMEOUT_EN undefined: the counter is absent and the bridge waits indefinitely in REQ/WAIT.

Structure
REQ-026 Package apb2wb_pkg holds the state enum typedef and TIMEOUT_W=16.
REQ-027 The timeout counter is sub-module apb2wb_timer (inputs clear, enable; output expired), instantiated only under APB2WB_TIMEOUT_EN.

Verification
REQ-028 Write addr 0x04, data 0xDEADBEEF, pstrb 4'b0011 -> wb_adr_o=1, wb_sel_o=4'b0011, wb_we_o=1; ack -> pready_o one cycle, pslverr_o=0.
REQ-029 Read addr 0x20 with 2 stall cycles, then ack with dat 0x12345678 -> stb held 3 cycles, prdata_o=0x12345678, pready_o once.
REQ-030 Read with wb_err_i in place of ack -> pslverr_o=1, prdata_o=0.
REQ-031 With APB2WB_TIMEOUT_EN and TIMEOUT=8, no response -> cyc drops after 8 cycles, pslverr_o=1; without the macro, cyc still high after 1000 cycles.
REQ-032 Same-cycle stb acceptance and ack -> direct REQ->DONE, pready_o at N+2.
REQ-033 rst_n_i asserted in WAIT -> wb_cyc_o=0 without a clock edge, no pready_o after release, next transfer completes normally.
